// File: rtl/pipeline_elastic_stage.sv
// pipeline_elastic_stage: parameterised elastic buffer between two valid/ready
// pipeline stages. Holds up to DEPTH entries in a circular buffer and hands them
// downstream in arrival order. Both handshake outputs are decoded purely from
// registered state, so this stage breaks every combinational path between the
// upstream and downstream handshakes.
module pipeline_elastic_stage #(
  parameter int               WIDTH  = 32,
  parameter int               DEPTH  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  // A single-entry buffer still needs a one-bit pointer to stay legal.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Handshake decode: registered state only, flush gates both transfers.
  assign in_ready  = (cnt != FULL_CNT);
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = cnt;

  // Oldest entry when occupied, otherwise the idle pattern; never from in_data.
  assign out_data  = out_valid ? mem[rd_ptr] : BUBBLE;

  // Occupancy and pointer state; reset and flush return to the empty state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage written on every accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; out_data is masked to
    // BUBBLE while empty, so stale contents are never observable.
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_pipeline_elastic_stage.sv
// tb_pipeline_elastic_stage: directed stimulus on three instances (DEPTH 2, 3
// and 1). Expected payloads go into per-instance queues when issued; a negedge
// monitor pops and compares whenever a transfer is presented downstream.
module tb_pipeline_elastic_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: WIDTH 32, DEPTH 2, BUBBLE DEADBEEF
  logic        a_flush = 0, a_in_valid = 0, a_out_ready = 0;
  logic [31:0] a_in_data = '0;
  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [1:0]  a_count;

  // Instance B: WIDTH 8, DEPTH 3, BUBBLE 0
  logic        b_flush = 0, b_in_valid = 0, b_out_ready = 0;
  logic [7:0]  b_in_data = '0;
  logic        b_in_ready, b_out_valid;
  logic [7:0]  b_out_data;
  logic [1:0]  b_count;

  // Instance C: WIDTH 16, DEPTH 1, BUBBLE 0
  logic        c_flush = 0, c_in_valid = 0, c_out_ready = 0;
  logic [15:0] c_in_data = '0;
  logic        c_in_ready, c_out_valid;
  logic [15:0] c_out_data;
  logic [0:0]  c_count;

  pipeline_elastic_stage #(.WIDTH(32), .DEPTH(2), .BUBBLE(32'hDEAD_BEEF)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count));

  pipeline_elastic_stage #(.WIDTH(8), .DEPTH(3), .BUBBLE(8'h00)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count));

  pipeline_elastic_stage #(.WIDTH(16), .DEPTH(1), .BUBBLE(16'h0000)) u_c (
    .clk(clk), .rst(rst), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .count(c_count));

  logic [31:0] exp_a[$];
  logic [7:0]  exp_b[$];
  logic [15:0] exp_c[$];
  int a_pops = 0;
  int c_pops = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a transfer presented now completes at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      if (a_out_valid && a_out_ready && !a_flush) begin
        a_pops++;
        if (exp_a.size() == 0) check("a_unexpected_out", 64'(a_out_data), 64'hFFFF_FFFF_FFFF_FFFF);
        else check("a_order", 64'(a_out_data), 64'(exp_a.pop_front()));
      end
      if (b_out_valid && b_out_ready && !b_flush) begin
        if (exp_b.size() == 0) check("b_unexpected_out", 64'(b_out_data), 64'hFFFF_FFFF_FFFF_FFFF);
        else check("b_order", 64'(b_out_data), 64'(exp_b.pop_front()));
      end
      if (c_out_valid && c_out_ready && !c_flush) begin
        c_pops++;
        if (exp_c.size() == 0) check("c_unexpected_out", 64'(c_out_data), 64'hFFFF_FFFF_FFFF_FFFF);
        else check("c_order", 64'(c_out_data), 64'(exp_c.pop_front()));
      end
    end
  end

  // DEPTH=3 interleaved table: per cycle valid, ready, data, in_ready before
  // the edge, count after the edge.
  bit         bv   [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
  bit         br   [11] = '{0, 0, 0, 1, 1, 1, 1, 0, 1, 1, 0};
  logic [7:0] bd   [11] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h14, 8'h15,
                            8'h16, 8'h17, 8'h00, 8'h00, 8'h00};
  bit         brdy [11] = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
  int         bcnt [11] = '{1, 2, 3, 2, 2, 2, 2, 3, 2, 1, 1};

  initial begin
    int base;

    // Reset values while rst is held low
    #2;
    check("a_rst_count", 64'(a_count), 64'd0);
    check("a_rst_out_valid", 64'(a_out_valid), 64'd0);
    check("a_rst_in_ready", 64'(a_in_ready), 64'd1);
    check("a_rst_bubble", 64'(a_out_data), 64'hDEAD_BEEF);
    check("b_rst_out_data", 64'(b_out_data), 64'd0);
    check("b_rst_in_ready", 64'(b_in_ready), 64'd1);
    check("c_rst_count", 64'(c_count), 64'd0);
    check("c_rst_out_valid", 64'(c_out_valid), 64'd0);

    // Back-pressure: A, B, C with out_ready low; first push on first edge after release
    #10;
    rst = 1'b1;
    a_in_valid = 1; a_in_data = 32'hA; exp_a.push_back(32'hA);
    step();
    check("a_latency_count", 64'(a_count), 64'd1);
    check("a_latency_valid", 64'(a_out_valid), 64'd1);
    check("a_latency_data", 64'(a_out_data), 64'hA);
    a_in_data = 32'hB; exp_a.push_back(32'hB);
    step();
    check("a_full_count", 64'(a_count), 64'd2);
    check("a_full_in_ready", 64'(a_in_ready), 64'd0);
    a_in_data = 32'hC; exp_a.push_back(32'hC);
    step();
    check("a_full_hold_count", 64'(a_count), 64'd2);
    a_out_ready = 1;
    step();
    check("a_slot_freed_count", 64'(a_count), 64'd1);
    check("a_slot_freed_ready", 64'(a_in_ready), 64'd1);
    step();
    a_in_valid = 0;
    check("a_push_pop_count", 64'(a_count), 64'd1);
    step();
    check("a_drained_count", 64'(a_count), 64'd0);
    check("a_drained_valid", 64'(a_out_valid), 64'd0);
    check("a_drained_bubble", 64'(a_out_data), 64'hDEAD_BEEF);
    check("a_bp_queue_empty", 64'(exp_a.size()), 64'd0);

    // Streaming 1..8 with out_ready high: count holds at 1
    base = a_pops;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1; a_in_data = 32'(i); exp_a.push_back(32'(i));
      step();
      check($sformatf("a_stream_count_%0d", i), 64'(a_count), 64'd1);
    end
    a_in_valid = 0;
    step();
    check("a_stream_end_count", 64'(a_count), 64'd0);
    check("a_stream_transfers", 64'(a_pops - base), 64'd8);
    check("a_stream_queue_empty", 64'(exp_a.size()), 64'd0);

    // Flush with a coincident push at count=2
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'h11;
    step();
    a_in_data = 32'h22;
    step();
    check("a_preflush_count", 64'(a_count), 64'd2);
    a_flush = 1; a_in_data = 32'h33;
    step();
    a_flush = 0; a_in_valid = 0;
    check("a_flush_count", 64'(a_count), 64'd0);
    check("a_flush_valid", 64'(a_out_valid), 64'd0);
    check("a_flush_bubble", 64'(a_out_data), 64'hDEAD_BEEF);
    check("a_flush_in_ready", 64'(a_in_ready), 64'd1);
    step();
    check("a_flush_push_dropped", 64'(a_count), 64'd0);
    a_in_valid = 1; a_in_data = 32'h44; exp_a.push_back(32'h44);
    step();
    a_in_valid = 0;
    check("a_postflush_data", 64'(a_out_data), 64'h44);
    a_out_ready = 1;
    step();
    check("a_postflush_count", 64'(a_count), 64'd0);
    check("a_flush_queue_empty", 64'(exp_a.size()), 64'd0);

    // Asynchronous reset between edges at count=2
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'h66;
    step();
    a_in_data = 32'h77;
    step();
    a_in_valid = 0;
    check("a_prerst_count", 64'(a_count), 64'd2);
    #3;
    rst = 1'b0;
    #1;
    check("a_async_rst_count", 64'(a_count), 64'd0);
    check("a_async_rst_valid", 64'(a_out_valid), 64'd0);
    check("a_async_rst_bubble", 64'(a_out_data), 64'hDEAD_BEEF);
    check("a_async_rst_ready", 64'(a_in_ready), 64'd1);
    a_in_valid = 1; a_in_data = 32'h5; exp_a.push_back(32'h5);
    #2;
    rst = 1'b1;
    step();
    a_in_valid = 0;
    check("a_postrst_count", 64'(a_count), 64'd1);
    check("a_postrst_data", 64'(a_out_data), 64'h5);
    a_out_ready = 1;
    step();
    a_out_ready = 0;
    check("a_postrst_drained", 64'(a_count), 64'd0);
    check("a_rst_queue_empty", 64'(exp_a.size()), 64'd0);

    // DEPTH=3: seven pushes interleaved with pops, both pointers wrap twice
    for (int i = 0; i < 7; i++) exp_b.push_back(8'(8'h11 + i));
    for (int i = 0; i < 11; i++) begin
      b_in_valid = bv[i]; b_out_ready = br[i]; b_in_data = bd[i];
      check($sformatf("b_in_ready_c%0d", i + 1), 64'(b_in_ready), 64'(brdy[i]));
      step();
      check($sformatf("b_count_c%0d", i + 1), 64'(b_count), 64'(bcnt[i]));
    end
    b_in_valid = 0; b_out_ready = 1;
    step();
    b_out_ready = 0;
    check("b_final_count", 64'(b_count), 64'd0);
    check("b_final_bubble", 64'(b_out_data), 64'd0);
    check("b_queue_empty", 64'(exp_b.size()), 64'd0);

    // DEPTH=1: continuous valid/ready, one transfer every other cycle
    for (int i = 0; i < 5; i++) exp_c.push_back(16'(16'h101 + i));
    base = c_pops;
    for (int i = 0; i < 10; i++) begin
      c_in_valid = 1; c_out_ready = 1; c_in_data = 16'(16'h101 + i / 2);
      check($sformatf("c_in_ready_c%0d", i + 1), 64'(c_in_ready), 64'((i % 2) == 0));
      step();
    end
    c_in_valid = 0; c_out_ready = 0;
    check("c_final_count", 64'(c_count), 64'd0);
    check("c_transfers", 64'(c_pops - base), 64'd5);
    check("c_queue_empty", 64'(exp_c.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipeline_elastic_stage.md
PIPELINE_ELASTIC_STAGE -- requirements
Module: pipeline_elastic_stage

Interface
REQ-001 Parameter WIDTH, default 32, is the payload width in bits; legal values are 1 or more.
REQ-002 Parameter DEPTH, default 2, is the number of buffer entries; legal values are 1 or more, and DEPTH need not be a power of two.
REQ-003 Parameter BUBBLE, default 0 (WIDTH bits), is the value driven on out_data whenever the stage holds no entry.
REQ-004 Port clk  input  1  is the sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  is the reset: asynchronous, active-low.
REQ-006 Port flush  input  1  is a synchronous discard of all held entries.
REQ-007 Port in_valid  input  1  means the upstream stage offers in_data this cycle.
REQ-008 Port in_ready  output  1  means the stage accepts in_data this cycle.
REQ-009 Port in_data  input  WIDTH  is the upstream payload.
REQ-010 Port out_valid  output  1  means out_data holds a valid entry.
REQ-011 Port out_ready  input  1  means the downstream stage consumes out_data this cycle.
REQ-012 Port out_data  output  WIDTH  is the oldest held entry, or BUBBLE when the stage is empty.
REQ-013 Port count  output  $clog2(DEPTH+1)  is the current number of held entries.

Function
REQ-014 A push SHALL occur on a rising edge when in_valid && in_ready && !flush.
REQ-015 A pop SHALL occur on a rising edge when out_valid && out_ready && !flush.
REQ-016 in_ready SHALL equal (count != DEPTH), decoded from registered state only, with no combinational path from out_ready or in_valid.
REQ-017 out_valid SHALL equal (count != 0), decoded from registered state only.
REQ-018 out_data SHALL be the entry at the read pointer when out_valid=1, else BUBBLE, with no combinational path from in_data.
REQ-019 Entries SHALL leave in push order (FIFO), and minimum in-to-out latency SHALL be 1 cycle: data pushed at edge N appears on out_data after edge N when the stage was empty.
REQ-020 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-021 A push alone SHALL increment count, and a pop alone SHALL decrement count.
REQ-022 The read and write pointers SHALL each wrap from DEPTH-1 to 0.
REQ-023 Full boundary: at count=DEPTH, in_ready=0, and an offered in_valid is neither stored nor lost upstream (upstream holds it); a pop in that cycle frees a slot visible the next cycle.
REQ-024 Empty boundary: at count=0, out_valid=0 and out_data=BUBBLE, and out_ready is ignored.
REQ-025 With DEPTH=1, sustained throughput SHALL be one entry per 2 cycles; with DEPTH of 2 or more, it SHALL be one entry per cycle while out_ready=1.
REQ-026 A flush=1 edge SHALL set count=0 and both pointers to 0, and SHALL ignore any coincident push or pop.
REQ-027 After a flush, out_data SHALL equal BUBBLE the cycle after the flush edge.
REQ-028 Storage contents need not be cleared by flush or reset; only pointers and count are architectural.
REQ-029 count SHALL never exceed DEPTH and never underflow, under any input sequence.

Reset
REQ-030 rst=0 SHALL immediately (asynchronously) force count=0, read pointer=0 and write pointer=0, giving out_valid=0, out_data=BUBBLE and in_ready=1.
REQ-031 Reset asserted mid-operation SHALL discard all held entries, and no partial push SHALL survive.
REQ-032 The first push SHALL be accepted on the first rising edge after rst deasserts, provided in_valid=1.
REQ-033 All outputs SHALL be defined with no X values during reset, for any parameter set.

Verification
REQ-034 Scenario (WIDTH=32, DEPTH=2): push 0xA, 0xB, 0xC on consecutive cycles with out_ready=0 -> after 2 edges count=2 and in_ready=0; 0xC is held by upstream; then out_ready=1 -> out_data reads 0xA, 0xB, 0xC in order.
REQ-035 Scenario: out_ready=1 and in_valid=1 for 8 cycles with data 1..8 (DEPTH=2) -> exactly one entry out per cycle, outputs 1..8, and count stays at 1 throughout.
REQ-036 Scenario: DEPTH=3, 7 pushes interleaved with pops -> pointers wrap across 2->0 twice with no reorder or loss, and count ends at the expected value.
REQ-037 Scenario: count=2 with flush=1 and in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, out_data=BUBBLE (test with BUBBLE=0xDEAD_BEEF), and the flushed-cycle data is absent.
REQ-038 Scenario: drive rst=0 asynchronously between clock edges while count=2 -> outputs go to their reset values before the next edge, and after release the first pushed value 0x5 is the first out.
REQ-039 Scenario: DEPTH=1, continuous in_valid=1 and out_ready=1 for 10 cycles -> 5 entries transferred, with in_ready alternating 1/0.
